// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU/I/O masters, the arbiter and the SRAM controller port.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface mem_arbiter_if;
   logic [17:0] cpu_addr;
   logic [35:0] cpu_wdata;
   logic        cpu_read;
   logic        cpu_write;
   logic        cpu_user;
   logic        cpu_ack;
   logic [17:0] io_addr;
   logic [35:0] io_wdata;
   logic        io_read;
   logic        io_write;
   logic        io_ack;
   logic [35:0] rd_data;
   logic        nxm;
   logic [17:0] mem_addr;
   logic [35:0] mem_write_data;
   logic        mem_read;
   logic        mem_write;
   logic        mem_user;
   logic [35:0] mem_read_data;
   logic        mem_ack;

   modport slave (
      input  cpu_addr, cpu_wdata, cpu_read, cpu_write, cpu_user,
      input  io_addr, io_wdata, io_read, io_write,
      input  mem_read_data, mem_ack,
      output cpu_ack, io_ack, rd_data, nxm,
      output mem_addr, mem_write_data, mem_read, mem_write, mem_user
   );

   modport master (
      output cpu_addr, cpu_wdata, cpu_read, cpu_write, cpu_user,
      output io_addr, io_wdata, io_read, io_write,
      output mem_read_data, mem_ack,
      input  cpu_ack, io_ack, rd_data, nxm,
      input  mem_addr, mem_write_data, mem_read, mem_write, mem_user
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master (CPU, I/O) arbiter onto the SRAM controller port with NXM timeout.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed I/O-over-CPU priority.
module mem_arbiter #(
   parameter int TIMEOUT = 255,
   parameter int TW      = 8
) (
   input logic         clk,
   input logic         reset_n,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, BUSY, HOLD, DRAIN} state_t;
   typedef enum logic [1:0] {G_NONE, G_CPU, G_IO} grant_t;

   state_t        state, state_n;
   grant_t        grant, grant_n;
   logic [TW-1:0] cnt, cnt_n;
   logic          ack, ack_n;
   logic          nxm, nxm_n;
   logic          mrd, mrd_n;
   logic          mwr, mwr_n;
   logic [35:0]   rdat, rdat_n;

   logic cpu_req, io_req, gnt_req, pick_io;

   assign cpu_req = bus.cpu_read | bus.cpu_write;
   assign io_req  = bus.io_read  | bus.io_write;
   assign gnt_req = (grant == G_CPU) ? cpu_req :
                    (grant == G_IO)  ? io_req  : 1'b0;

`ifdef MEM_ARB_RR_EN
   // last_io: which master was served last; the other one wins a collision
   logic last_io;
   assign pick_io = io_req & (~cpu_req | ~last_io);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                               last_io <= 1'b0;
      else if (state_n == DRAIN && state != DRAIN) last_io <= (grant == G_IO);
   end
`else
   assign pick_io = io_req;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         grant <= G_NONE;
         cnt   <= '0;
         ack   <= 1'b0;
         nxm   <= 1'b0;
         mrd   <= 1'b0;
         mwr   <= 1'b0;
         rdat  <= '0;
      end else begin
         state <= state_n;
         grant <= grant_n;
         cnt   <= cnt_n;
         ack   <= ack_n;
         nxm   <= nxm_n;
         mrd   <= mrd_n;
         mwr   <= mwr_n;
         rdat  <= rdat_n;
      end
   end

   always_comb begin
      state_n = state;
      grant_n = grant;
      cnt_n   = cnt;
      ack_n   = ack;
      nxm_n   = 1'b0;
      mrd_n   = mrd;
      mwr_n   = mwr;
      rdat_n  = rdat;
      case (state)
         IDLE: if (cpu_req || io_req) begin
            grant_n = pick_io ? G_IO : G_CPU;
            // read+write together is a write
            mwr_n   = pick_io ? bus.io_write : bus.cpu_write;
            mrd_n   = ~mwr_n;
            cnt_n   = '0;
            state_n = BUSY;
         end
         BUSY: begin
            if (!gnt_req) begin
               mrd_n   = 1'b0;
               mwr_n   = 1'b0;
               state_n = DRAIN;
            end else if (bus.mem_ack) begin
               ack_n   = 1'b1;
               if (mrd) rdat_n = bus.mem_read_data;
               state_n = HOLD;
            end else begin
               cnt_n = cnt + 1'b1;
               if (cnt_n == TW'(TIMEOUT)) begin
                  nxm_n   = 1'b1;
                  rdat_n  = '0;
                  ack_n   = 1'b1;
                  state_n = HOLD;
               end
            end
         end
         HOLD: if (!gnt_req) begin
            ack_n   = 1'b0;
            mrd_n   = 1'b0;
            mwr_n   = 1'b0;
            state_n = DRAIN;
         end
         DRAIN: if (!bus.mem_ack) begin
            state_n = IDLE;
            grant_n = G_NONE;
            cnt_n   = '0;
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.cpu_ack   = ack & (grant == G_CPU);
   assign bus.io_ack    = ack & (grant == G_IO);
   assign bus.rd_data   = rdat;
   assign bus.nxm       = nxm;
   assign bus.mem_read  = mrd;
   assign bus.mem_write = mwr;

   // Address/data pass straight through so the granted master owns their stability
   always_comb begin
      bus.mem_addr       = '0;
      bus.mem_write_data = '0;
      bus.mem_user       = 1'b0;
      case (grant)
         G_CPU: begin
            bus.mem_addr       = bus.cpu_addr;
            bus.mem_write_data = bus.cpu_wdata;
            bus.mem_user       = bus.cpu_user;
         end
         G_IO: begin
            bus.mem_addr       = bus.io_addr;
            bus.mem_write_data = bus.io_wdata;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected acks, a monitor checks them.
module tb_mem_arbiter;
   localparam int TO = 16;

   typedef struct packed {
      logic        io;
      logic [35:0] rd;
      logic        nxm;
   } exp_t;

   logic clk;
   logic reset_n;
   int   lat;
   int   mcnt;
   int   checks;
   int   errors;
   int   nxm_cnt;
   exp_t q[$];

   mem_arbiter_if bus();

   mem_arbiter #(.TIMEOUT(TO), .TW(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Controller model: level ack lat cycles after the request, dropped once the request drops
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.mem_ack <= 1'b0;
         mcnt        <= 0;
      end else if (!(bus.mem_read || bus.mem_write)) begin
         bus.mem_ack <= 1'b0;
         mcnt        <= 0;
      end else if (!bus.mem_ack) begin
         if (lat != 0 && mcnt == lat - 1) bus.mem_ack <= 1'b1;
         mcnt <= mcnt + 1;
      end
   end

   assign bus.mem_read_data = (bus.mem_addr == 18'o001234) ? 36'o123456701234
                                                           : {bus.mem_addr, bus.mem_addr};

   task automatic chk(input string nm, input logic [35:0] got, input logic [35:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0o, expected %0o", nm, got, exp);
      end
   endtask

   task automatic expect_ack(input bit io, input logic [35:0] rd, input bit nx);
      exp_t e;
      e = '{io: io, rd: rd, nxm: nx};
      q.push_back(e);
   endtask

   task automatic drive(input bit io, input logic [17:0] addr, input logic [35:0] wd, input bit wr);
      if (io) begin
         bus.io_addr  = addr;
         bus.io_wdata = wd;
         bus.io_write = wr;
         bus.io_read  = ~wr;
      end else begin
         bus.cpu_addr  = addr;
         bus.cpu_wdata = wd;
         bus.cpu_write = wr;
         bus.cpu_read  = ~wr;
      end
   endtask

   task automatic release_req(input bit io);
      if (io) begin
         bus.io_read  = 1'b0;
         bus.io_write = 1'b0;
      end else begin
         bus.cpu_read  = 1'b0;
         bus.cpu_write = 1'b0;
      end
   endtask

   task automatic wait_ack(input bit io);
      int n;
      n = 0;
      while (!(io ? bus.io_ack : bus.cpu_ack) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL wait_ack: no %s ack within 100 cycles", io ? "io" : "cpu");
      end
   endtask

   task automatic finish_txn(input bit io);
      wait_ack(io);
      repeat (2) @(negedge clk);
      release_req(io);
      repeat (3) @(negedge clk);
   endtask

   task automatic collide(input bit first_io);
      lat = 2;
      expect_ack(first_io,  first_io ? 36'o000200000200 : 36'o000300000300, 1'b0);
      expect_ack(!first_io, first_io ? 36'o000300000300 : 36'o000200000200, 1'b0);
      drive(1'b1, 18'o000200, 36'o0, 1'b0);
      drive(1'b0, 18'o000300, 36'o0, 1'b0);
      finish_txn(first_io);
      finish_txn(!first_io);
   endtask

   // Monitor: pops one expectation per rising ack and checks data, nxm and latency
   initial begin : monitor
      bit p_ack, p_rw, p_mack;
      int cyc, rw_c, mack_c;
      exp_t e;
      p_ack = 0; p_rw = 0; p_mack = 0;
      cyc = 0; rw_c = 0; mack_c = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset_n) begin
            p_ack = 0; p_rw = 0; p_mack = 0;
         end else begin
            if (bus.nxm) nxm_cnt++;
            if ((bus.mem_read || bus.mem_write) && !p_rw) rw_c = cyc;
            if (bus.mem_ack && !p_mack) mack_c = cyc;
            if ((bus.cpu_ack || bus.io_ack) && !p_ack) begin
               if (q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_ack: cpu_ack=%0b io_ack=%0b, none expected",
                           bus.cpu_ack, bus.io_ack);
               end else begin
                  e = q.pop_front();
                  chk("ack_io",  36'(bus.io_ack),  36'(e.io));
                  chk("ack_cpu", 36'(bus.cpu_ack), 36'(!e.io));
                  chk("ack_rd_data", bus.rd_data, e.rd);
                  chk("ack_nxm", 36'(bus.nxm), 36'(e.nxm));
                  if (e.nxm) chk("nxm_latency", 36'(cyc - rw_c), 36'(TO));
                  else       chk("ack_latency", 36'(cyc - mack_c), 36'd1);
               end
            end
            p_ack  = bus.cpu_ack || bus.io_ack;
            p_rw   = bus.mem_read || bus.mem_write;
            p_mack = bus.mem_ack;
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin : stim
      int n0, fa, ra, i;
      checks = 0; errors = 0; nxm_cnt = 0; lat = 0;
      reset_n = 1'b0;
      bus.cpu_addr = 18'o777777; bus.cpu_wdata = '1; bus.cpu_user = 1'b1;
      bus.cpu_read = 1'b0; bus.cpu_write = 1'b0;
      bus.io_addr = 18'o777777; bus.io_wdata = '1;
      bus.io_read = 1'b0; bus.io_write = 1'b0;

      // Reset state, with non-zero master inputs behind an empty grant
      #3;
      chk("rst_cpu_ack",   36'(bus.cpu_ack), 36'd0);
      chk("rst_io_ack",    36'(bus.io_ack),  36'd0);
      chk("rst_rd_data",   bus.rd_data,      36'd0);
      chk("rst_nxm",       36'(bus.nxm),     36'd0);
      chk("rst_mem_addr",  36'(bus.mem_addr), 36'd0);
      chk("rst_mem_wdata", bus.mem_write_data, 36'd0);
      chk("rst_mem_read",  36'(bus.mem_read),  36'd0);
      chk("rst_mem_write", 36'(bus.mem_write), 36'd0);
      chk("rst_mem_user",  36'(bus.mem_user),  36'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // CPU read, controller acks after 6 cycles
      lat = 6;
      expect_ack(1'b0, 36'o123456701234, 1'b0);
      drive(1'b0, 18'o001234, 36'o0, 1'b0);
      repeat (2) @(negedge clk);
      chk("cpu_rd_mem_read", 36'(bus.mem_read), 36'd1);
      chk("cpu_rd_mem_user", 36'(bus.mem_user), 36'd1);
      chk("cpu_rd_mem_addr", 36'(bus.mem_addr), 36'o001234);
      finish_txn(1'b0);

      // I/O write: user forced 0, rd_data left at the previous read value
      lat = 3;
      expect_ack(1'b1, 36'o123456701234, 1'b0);
      drive(1'b1, 18'o000100, 36'o777000777000, 1'b1);
      repeat (2) @(negedge clk);
      chk("io_wr_mem_write", 36'(bus.mem_write), 36'd1);
      chk("io_wr_mem_read",  36'(bus.mem_read),  36'd0);
      chk("io_wr_mem_user",  36'(bus.mem_user),  36'd0);
      chk("io_wr_mem_wdata", bus.mem_write_data, 36'o777000777000);
      chk("io_wr_mem_addr",  36'(bus.mem_addr),  36'o000100);
      finish_txn(1'b1);

      // Collision from reset pointer: I/O first in both builds
      collide(1'b1);

      // I/O alone, then a second collision
      lat = 2;
      expect_ack(1'b1, 36'o000200000200, 1'b0);
      drive(1'b1, 18'o000200, 36'o0, 1'b0);
      finish_txn(1'b1);
`ifdef MEM_ARB_RR_EN
      collide(1'b0);
`else
      collide(1'b1);
`endif

      // Timeout: no ack, nxm once, TO cycles into BUSY
      lat = 0;
      n0 = nxm_cnt;
      expect_ack(1'b0, 36'd0, 1'b1);
      drive(1'b0, 18'o000500, 36'o0, 1'b0);
      wait_ack(1'b0);
      repeat (3) @(negedge clk);
      chk("to_hold_mem_read", 36'(bus.mem_read), 36'd1);
      chk("to_hold_cpu_ack",  36'(bus.cpu_ack),  36'd1);
      release_req(1'b0);
      @(negedge clk);
      chk("to_drop_mem_read", 36'(bus.mem_read), 36'd0);
      chk("to_drop_cpu_ack",  36'(bus.cpu_ack),  36'd0);
      repeat (2) @(negedge clk);
      chk("to_nxm_pulses", 36'(nxm_cnt - n0), 36'd1);

      // Abort 2 cycles into BUSY; next grant must wait for mem_ack to fall
      lat = 2;
      drive(1'b0, 18'o000700, 36'o0, 1'b0);
      repeat (2) @(negedge clk);
      release_req(1'b0);
      expect_ack(1'b1, 36'o000100000100, 1'b0);
      drive(1'b1, 18'o000100, 36'o0, 1'b0);
      @(negedge clk);
      chk("abort_mem_read", 36'(bus.mem_read), 36'd0);
      chk("abort_cpu_ack",  36'(bus.cpu_ack),  36'd0);
      fa = -1; ra = -1; i = 0;
      while (ra < 0 && i < 20) begin
         if (fa < 0 && !bus.mem_ack) fa = i;
         if (bus.mem_read) ra = i;
         if (ra < 0) begin
            @(negedge clk);
            i++;
         end
      end
      chk("abort_drain_gap", 36'(ra - fa), 36'd2);
      finish_txn(1'b1);

      // Asynchronous reset in the middle of a transaction
      lat = 0;
      drive(1'b0, 18'o001234, 36'o0, 1'b0);
      repeat (3) @(negedge clk);
      chk("pre_rst_mem_read", 36'(bus.mem_read), 36'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_mem_read",  36'(bus.mem_read),  36'd0);
      chk("mid_rst_mem_write", 36'(bus.mem_write), 36'd0);
      chk("mid_rst_cpu_ack",   36'(bus.cpu_ack),   36'd0);
      chk("mid_rst_io_ack",    36'(bus.io_ack),    36'd0);
      chk("mid_rst_nxm",       36'(bus.nxm),       36'd0);
      release_req(1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      lat = 3;
      expect_ack(1'b0, 36'o123456701234, 1'b0);
      drive(1'b0, 18'o001234, 36'o0, 1'b0);
      finish_txn(1'b0);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 36'(q.size()), 36'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master arbiter directly upstream of the SRAM memory controller.
- Multiplexes CPU and I/O (console/DMA) memory requests onto the single processor-side memory port (mem_addr/mem_read/mem_write/mem_ack handshake).
- Holds each transaction through the controller's level-ack handshake and returns data and ack to the winning master.
- Times out missing acks as NXM (non-existent memory), PDP-10 style.

Parameters:
- TIMEOUT, 255: cycles in BUSY without mem_ack before NXM is declared (1..255).
- TW, 8: timeout counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset_n  in  1  asynchronous active-low reset.
- cpu_addr  in  18  CPU word address.
- cpu_wdata  in  36  CPU write data, bits [0:35].
- cpu_read  in  1  CPU read request, level, held until cpu_ack.
- cpu_write  in  1  CPU write request, level, held until cpu_ack.
- cpu_user  in  1  CPU user/exec space select.
- cpu_ack  out  1  CPU transaction complete, level.
- io_addr  in  18  I/O word address.
- io_wdata  in  36  I/O write data.
- io_read  in  1  I/O read request.
- io_write  in  1  I/O write request.
- io_ack  out  1  I/O transaction complete, level.
- rd_data  out  36  read data for the acked master; valid while that master's ack=1.
- nxm  out  1  one-cycle pulse on timeout.
- mem_addr  out  18  to controller.
- mem_write_data  out  36  to controller.
- mem_read  out  1  to controller.
- mem_write  out  1  to controller.
- mem_user  out  1  to controller.
- mem_read_data  in  36  from controller.
- mem_ack  in  1  from controller; level, held until mem_read/mem_write drop.

Behaviour:
- Reset (async, reset_n=0):
  - All outputs 0, rd_data=0.
  - State IDLE, grant=none, timeout counter=0, round-robin pointer=CPU.
  - Reset mid-transaction drops mem_read/mem_write immediately. No ack is issued.
- States: IDLE, BUSY, HOLD, DRAIN.
- Request from a master = read|write.
- read and write both asserted: treated as write.
- IDLE:
  - On a posedge with any request: latch grant. Both requesting: I/O wins (fixed priority).
  - Go to BUSY; assert mem_read or mem_write (registered) next cycle.
- Muxing (combinational from grant):
  - mem_addr, mem_write_data and mem_user follow the granted master's inputs.
  - mem_user=0 for I/O.
  - All mux outputs 0 when grant=none.
- BUSY:
  - Counter increments each cycle while mem_ack=0.
  - mem_ack=1: register mem_read_data into rd_data (reads only; writes leave rd_data unchanged), assert granted master's ack, go to HOLD. Latency = mem_ack sampled → master ack 1 cycle.
  - Counter reaches TIMEOUT: rd_data=0, pulse nxm for one cycle, assert granted ack, go to HOLD.
  - Granted master drops its request before ack (abort): no ack, go to DRAIN.
- HOLD:
  - mem_read/mem_write stay asserted; ack held.
  - When the granted master drops its request: clear ack and mem_read/mem_write the same edge, go to DRAIN.
- DRAIN:
  - Wait for mem_ack=0, then go to IDLE with grant=none and counter=0.
  - Guarantees the controller sees at least one idle cycle between transactions.
- Ungranted master requests wait unacknowledged; no queuing beyond the level request.
- Request changes from the granted master (address/data) during BUSY/HOLD are passed through unregistered and are the master's responsibility.

Optional Feature:
- MEM_ARB_RR_EN defined: round-robin arbitration. When both request in IDLE, the master not served last wins. The pointer updates on entry to DRAIN.
- MEM_ARB_RR_EN not defined: fixed I/O-over-CPU priority.
- All other behaviour is identical in both builds.

Test Plan:
- CPU read, addr 0o001234, controller model acks 6 cycles later with 36'o123456701234 → mem_read held 6 cycles; cpu_ack=1 one cycle after mem_ack; rd_data=36'o123456701234; io_ack stays 0.
- I/O write addr 0o000100, data 36'o777000777000 → mem_write=1, mem_user=0, mem_write_data=36'o777000777000; io_ack after mem_ack; rd_data unchanged.
- CPU and I/O request reads on the same edge → I/O served first, then CPU after DRAIN. With MEM_ARB_RR_EN, a repeat collision serves CPU first.
- TIMEOUT=16, controller never acks CPU read → nxm pulses exactly once 16 cycles into BUSY; cpu_ack=1; rd_data=0; mem_read drops when cpu_read drops.
- reset_n low while BUSY (mem_read=1) → mem_read, all acks and nxm go 0 asynchronously; after release, a new CPU read completes normally.
- CPU aborts (cpu_read drops) 2 cycles into BUSY → no cpu_ack; mem_read drops; state returns to IDLE only after mem_ack=0.
